nv_clk_gate_ctrl: RTL and testbench

- Generates the clock-enable for the power clock-gate cell (NV_CLK_gate_power.clk_en) of one clock-gated partition.
- Runs on the ungated clock.
- Monitors partition busy flags and an upstream wake request, gates the clock after a programmable idle hysteresis, and re-enables it with a fixed settle delay before acknowledging wake.
- All outputs are registered, so clk_en into the gate cell is glitch-free.

---
 rtl/nv_clk_gate_pkg.sv | 23 ++
 rtl/nv_clk_gate_ctrl.sv | 135 +++++++++++++
 tb/tb_nv_clk_gate_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/nv_clk_gate_pkg.sv
// Shared constants for the partition clock-gate controller: state encoding and wake-delay range.
// Latency: n/a (package). Backpressure: n/a.
package nv_clk_gate_pkg;

    localparam int unsigned GATE_STATE_W = 2;

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_OFF  = 2'd2;
    localparam logic [1:0] ST_WAKE = 2'd3;

    localparam int unsigned WAKE_DLY_MIN = 1;
    localparam int unsigned WAKE_DLY_MAX = 15;
    localparam int unsigned WAKE_CNT_W   = 4;

    // Out-of-range delays are clamped so the wake counter can always reach its terminal value.
    function automatic int unsigned clamp_wake_dly(input int unsigned dly);
        if (dly < WAKE_DLY_MIN) return WAKE_DLY_MIN;
        if (dly > WAKE_DLY_MAX) return WAKE_DLY_MAX;
        return dly;
    endfunction

endpackage

// File: rtl/nv_clk_gate_ctrl.sv
// Clock-enable controller for one gated partition: gates after idle hysteresis, re-enables on activity.
// Latency: clk_en rises one edge after activity in OFF, wake_ack WAKE_DLY edges later; 0-cycle ack in RUN/HOLD.
// Backpressure: wake_req is held by upstream until wake_ack; all outputs registered, no input-to-clk_en path.
module nv_clk_gate_ctrl
    import nv_clk_gate_pkg::*;
#(
    parameter int unsigned NUM_SRC  = 4,
    parameter int unsigned HYST_W   = 8,
    parameter int unsigned WAKE_DLY = 2,
    parameter int unsigned CNT_W    = 16
) (
    input  logic               clk,
    input  logic               reset_,
    input  logic               cfg_override,
    input  logic [HYST_W-1:0]  cfg_idle_hyst,
    input  logic [NUM_SRC-1:0] src_busy,
    input  logic               wake_req,
    output logic               wake_ack,
    output logic               clk_en,
    output logic [1:0]         gate_state,
    output logic [CNT_W-1:0]   gate_cnt
);

    localparam int unsigned           WAKE_DLY_C = clamp_wake_dly(WAKE_DLY);
    localparam logic [WAKE_CNT_W-1:0] WAKE_LAST  = WAKE_CNT_W'(WAKE_DLY_C - 1);
    localparam logic [WAKE_CNT_W-1:0] WAKE_ONE   = WAKE_CNT_W'(1);
    localparam logic [HYST_W-1:0]     IDLE_ONE   = HYST_W'(1);
    localparam logic [CNT_W-1:0]      CNT_ONE    = CNT_W'(1);

    logic [1:0]            state_q,    state_d;
    logic [HYST_W-1:0]     idle_cnt_q, idle_cnt_d;
    logic [WAKE_CNT_W-1:0] wake_cnt_q, wake_cnt_d;
    logic [CNT_W-1:0]      gate_cnt_q, gate_cnt_d;
    logic                  clk_en_q,   clk_en_d;
    logic                  wake_ack_q, wake_ack_d;

    logic                  activity;
    logic                  hyst_off;
    logic [HYST_W:0]       idle_next;
    logic                  hyst_hit;
    logic                  enter_off;

    assign hyst_off  = (cfg_idle_hyst == '0);
    assign activity  = (|src_busy) | wake_req | cfg_override | hyst_off;
    // Widened so the compare against the live threshold cannot wrap.
    assign idle_next = {1'b0, idle_cnt_q} + {{HYST_W{1'b0}}, 1'b1};
    assign hyst_hit  = (idle_next >= {1'b0, cfg_idle_hyst});

    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        wake_cnt_d = wake_cnt_q;
        clk_en_d   = clk_en_q;
        wake_ack_d = wake_ack_q;
        enter_off  = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (activity) begin
                    idle_cnt_d = '0;
                end else if (cfg_idle_hyst == IDLE_ONE) begin
                    enter_off = 1'b1;
                end else begin
                    state_d    = ST_HOLD;
                    idle_cnt_d = IDLE_ONE;
                end
            end
            ST_HOLD: begin
                if (activity) begin
                    state_d    = ST_RUN;
                    idle_cnt_d = '0;
                end else if (hyst_hit) begin
                    enter_off = 1'b1;
                end else begin
                    idle_cnt_d = idle_next[HYST_W-1:0];
                end
            end
            ST_OFF: begin
                if (activity) begin
                    state_d    = ST_WAKE;
                    clk_en_d   = 1'b1;
                    wake_ack_d = 1'b0;
                    wake_cnt_d = '0;
                end
            end
            default: begin
                // WAKE runs to completion regardless of what activity does meanwhile.
                if (wake_cnt_q == WAKE_LAST) begin
                    state_d    = ST_RUN;
                    wake_ack_d = 1'b1;
                    idle_cnt_d = '0;
                end
                wake_cnt_d = wake_cnt_q + WAKE_ONE;
            end
        endcase

        if (enter_off) begin
            state_d    = ST_OFF;
            clk_en_d   = 1'b0;
            wake_ack_d = 1'b0;
            idle_cnt_d = '0;
        end
    end

    always_comb begin
        gate_cnt_d = gate_cnt_q;
        if (enter_off && (gate_cnt_q != {CNT_W{1'b1}})) begin
            gate_cnt_d = gate_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q    <= ST_RUN;
            idle_cnt_q <= '0;
            wake_cnt_q <= '0;
            gate_cnt_q <= '0;
            clk_en_q   <= 1'b1;
            wake_ack_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            wake_cnt_q <= wake_cnt_d;
            gate_cnt_q <= gate_cnt_d;
            clk_en_q   <= clk_en_d;
            wake_ack_q <= wake_ack_d;
        end
    end

    assign clk_en     = clk_en_q;
    assign wake_ack   = wake_ack_q;
    assign gate_state = state_q;
    assign gate_cnt   = gate_cnt_q;

endmodule

// File: tb/tb_nv_clk_gate_ctrl.sv
// Randomized and directed bench for nv_clk_gate_ctrl against a phase-level reference model.
module tb_nv_clk_gate_ctrl;

    localparam int NS = 4;
    localparam int HW = 8;
    localparam int WD = 2;
    localparam int CW = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset_;
    logic          cfg_override;
    logic [HW-1:0] cfg_idle_hyst;
    logic [NS-1:0] src_busy;
    logic          wake_req;
    logic          wake_ack;
    logic          clk_en;
    logic [1:0]    gate_state;
    logic [CW-1:0] gate_cnt;

    always #5 clk = ~clk;

    nv_clk_gate_ctrl #(
        .NUM_SRC (NS),
        .HYST_W  (HW),
        .WAKE_DLY(WD),
        .CNT_W   (CW)
    ) u_dut (
        .clk          (clk),
        .reset_       (reset_),
        .cfg_override (cfg_override),
        .cfg_idle_hyst(cfg_idle_hyst),
        .src_busy     (src_busy),
        .wake_req     (wake_req),
        .wake_ack     (wake_ack),
        .clk_en       (clk_en),
        .gate_state   (gate_state),
        .gate_cnt     (gate_cnt)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    // Reference model: the partition is gated, waking (with cycles left), or running with an idle run length.
    bit m_gated;
    int m_wake_left;
    int m_idle_run;
    int m_cnt;
    int xfer_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s @%0t: got %0h, want %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic bit act_now();
        return (|src_busy) || wake_req || cfg_override || (cfg_idle_hyst == 0);
    endfunction

    function automatic bit m_running();
        return !m_gated && (m_wake_left == 0);
    endfunction

    function automatic int m_state();
        if (m_gated)         return 2;
        if (m_wake_left > 0) return 3;
        if (m_idle_run > 0)  return 1;
        return 0;
    endfunction

    task automatic model_reset();
        m_gated     = 1'b0;
        m_wake_left = 0;
        m_idle_run  = 0;
        m_cnt       = 0;
    endtask

    task automatic model_step(input bit act, input int h);
        if (m_wake_left > 0) begin
            m_wake_left--;
        end else if (m_gated) begin
            if (act) begin
                m_gated     = 1'b0;
                m_wake_left = WD;
            end
        end else if (act) begin
            m_idle_run = 0;
        end else begin
            m_idle_run++;
            if (m_idle_run >= h) begin
                m_gated    = 1'b1;
                m_idle_run = 0;
                if (m_cnt < CNT_MAX) m_cnt++;
            end
        end
    endtask

    task automatic check_all();
        chk("clk_en",     32'(clk_en),     32'(!m_gated));
        chk("wake_ack",   32'(wake_ack),   32'(m_running()));
        chk("gate_state", 32'(gate_state), 32'(m_state()));
        chk("gate_cnt",   32'(gate_cnt),   32'(m_cnt));
    endtask

    task automatic step();
        bit a;
        int h;
        a = act_now();
        h = int'(cfg_idle_hyst);
        @(posedge clk);
        model_step(a, h);
        #1;
        check_all();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic apply_reset();
        reset_ = 1'b0;
        #2;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        reset_ = 1'b1;
    endtask

    initial begin
        reset_        = 1'b1;
        cfg_override  = 1'b0;
        cfg_idle_hyst = 8'd4;
        src_busy      = '0;
        wake_req      = 1'b0;
        xfer_cnt      = 0;
        model_reset();
        #3;

        // Power-on idle gating with H=4.
        apply_reset();
        chk("rst_state", 32'(gate_state), 32'd0);
        step();
        chk("hold_edge1", 32'(gate_state), 32'd1);
        steps(3);
        chk("off_edge4_en", 32'(clk_en), 32'd0);
        chk("off_edge4_cnt", 32'(gate_cnt), 32'd1);

        // Busy on idle cycle 3 returns to RUN without gating.
        apply_reset();
        steps(2);
        src_busy = 4'b0100;
        step();
        chk("busy_run", 32'(gate_state), 32'd0);
        src_busy = '0;
        steps(4);
        chk("reidle_off", 32'(gate_state), 32'd2);

        // Wake handshake from OFF.
        wake_req = 1'b1;
        step();
        chk("wake_en_rise", 32'(clk_en), 32'd1);
        step();
        chk("wake_ack_low", 32'(wake_ack), 32'd0);
        step();
        chk("wake_ack_rise", 32'(wake_ack), 32'd1);
        step();
        wake_req = 1'b0;
        steps(4);
        chk("regate", 32'(gate_state), 32'd2);

        // H=0 disables gating; lowering H mid-HOLD gates on the next idle edge.
        apply_reset();
        cfg_idle_hyst = 8'd0;
        steps(100);
        chk("h0_run", 32'(clk_en), 32'd1);
        cfg_idle_hyst = 8'd8;
        steps(5);
        cfg_idle_hyst = 8'd2;
        step();
        chk("h_lower_off", 32'(gate_state), 32'd2);

        // Override from OFF still passes through WAKE; activity loss in WAKE is ignored.
        cfg_override = 1'b1;
        src_busy     = 4'b0001;
        step();
        chk("ovr_wake", 32'(gate_state), 32'd3);
        src_busy = '0;
        steps(2);
        chk("ovr_run", 32'(gate_state), 32'd0);
        steps(20);
        chk("ovr_hold_en", 32'(clk_en), 32'd1);
        cfg_override = 1'b0;

        // Gate counter saturation.
        apply_reset();
        cfg_idle_hyst = 8'd1;
        for (int i = 0; i < CNT_MAX + 2; i++) begin
            step();
            wake_req = 1'b1;
            steps(3);
            wake_req = 1'b0;
        end
        chk("cnt_sat", 32'(gate_cnt), 32'(CNT_MAX));

        // Asynchronous reset in the middle of WAKE.
        step();
        wake_req = 1'b1;
        step();
        chk("pre_rst_wake", 32'(gate_state), 32'd3);
        reset_ = 1'b0;
        #2;
        model_reset();
        chk("arst_en",  32'(clk_en),   32'd1);
        chk("arst_ack", 32'(wake_ack), 32'd1);
        chk("arst_cnt", 32'(gate_cnt), 32'd0);
        check_all();
        wake_req = 1'b0;
        @(negedge clk);
        reset_ = 1'b1;

        // Random traffic with a well-behaved wake requester.
        cfg_idle_hyst = 8'd3;
        for (int c = 0; c < 3000; c++) begin
            bit do_xfer;
            if ($urandom_range(0, 63) == 0) cfg_idle_hyst = HW'($urandom_range(0, 6));
            if ($urandom_range(0, 49) == 0) cfg_override = ~cfg_override;
            src_busy = ($urandom_range(0, 3) == 0) ? NS'($urandom) : '0;
            if (!wake_req && $urandom_range(0, 15) == 0) wake_req = 1'b1;
            do_xfer = wake_req && m_running();
            step();
            if (do_xfer) begin
                xfer_cnt++;
                wake_req = 1'b0;
            end
        end
        chk("xfers_seen", 32'(xfer_cnt > 0), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
